// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants for the rx/tx datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Value presented on byte outputs whenever no byte is available
    localparam uart_byte_t UART_IDLE_BYTE = '0;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Generic first-word-fall-through FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic w_full;
    logic w_empty;
    logic w_do_wr;
    logic w_do_rd;

    assign w_full  = (r_level == C_FULL_LVL);
    assign w_empty = (r_level == '0);
    // When full, a write is only legal if a read frees the head slot this edge
    assign w_do_wr = wr_en & (~w_full | rd_en);
    assign w_do_rd = rd_en & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;
    assign full    = w_full;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receive byte buffer with valid/ready output and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [UART_DATA_W-1:0]   rx_data,
    input  logic                     rx_done,
    output logic [UART_DATA_W-1:0]   m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] C_AFULL_LVL = LW'(AFULL_LVL);

    logic             r_rx_done_q;
    logic             r_overflow;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_valid;
    uart_byte_t       w_head;
    logic [LW-1:0]    w_level;

    assign w_push  = rx_done & ~r_rx_done_q;
    assign w_valid = (w_level != '0);
    assign w_pop   = w_valid & m_ready;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_push),
        .wr_data (rx_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .level   (w_level),
        .full    (w_full)
    );

    // A set in the same cycle as a clear takes priority so no drop is missed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_done_q <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_rx_done_q <= rx_done;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign m_valid     = w_valid;
    assign m_data      = w_valid ? w_head : UART_IDLE_BYTE;
    assign level       = w_level;
    assign almost_full = (w_level >= C_AFULL_LVL);
    assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a
// negedge monitor checks every accepted handshake against the queue.
`default_nettype none

module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] level;
    logic       almost_full;
    logic       overflow;
    logic       overflow_clr;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(.DEPTH(16), .AFULL_LVL(12)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must deliver the oldest outstanding byte
    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL pop_unexpected: got %0h expected no data", m_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    mismatched++;
                    $display("FAIL pop_data: got %0h expected %0h", m_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0;
        m_ready = 1'b0; overflow_clr = 1'b0;
        step(); step();
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 8'h00);
        check("rst_level", level, 0);
        check("rst_afull", almost_full, 0);
        check("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        step();

        // Single pulse, visible the cycle after the sampling edge
        rx_data = 8'hA5; rx_done = 1'b1;
        exp_q.push_back(8'hA5);
        step();
        check("t1_valid", m_valid, 1);
        check("t1_data", m_data, 8'hA5);
        check("t1_level", level, 1);
        rx_done = 1'b0; m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("t1_level_after_pop", level, 0);
        check("t1_data_empty", m_data, 8'h00);

        // Held level pushes exactly once
        rx_data = 8'h3C; rx_done = 1'b1;
        exp_q.push_back(8'h3C);
        repeat (5) step();
        rx_done = 1'b0;
        step();
        check("t2_level", level, 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("t2_level_drained", level, 0);

        // 17 pushes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            rx_data = 8'(i); rx_done = 1'b1;
            if (i < 16) exp_q.push_back(8'(i));
            step();
            check("t3_afull", almost_full, (i + 1 >= 12 && i < 17) ? 1 : 0);
            check("t3_level", level, (i < 16) ? i + 1 : 16);
            rx_done = 1'b0;
            step();
        end
        check("t3_ovf", overflow, 1);

        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("t4_ovf_cleared", overflow, 0);

        // Full: push and pop together, new byte lands last
        rx_data = 8'h55; rx_done = 1'b1; m_ready = 1'b1;
        exp_q.push_back(8'h55);
        step();
        rx_done = 1'b0; m_ready = 1'b0;
        check("t4_level", level, 16);
        check("t4_ovf", overflow, 0);
        step();

        // Drop sets overflow; set beats a coincident clear
        rx_data = 8'h77; rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        check("t5_ovf_set", overflow, 1);
        step();
        rx_data = 8'h78; rx_done = 1'b1; overflow_clr = 1'b1;
        step();
        rx_done = 1'b0;
        check("t5_set_wins", overflow, 1);
        step();
        check("t5_ovf_clear", overflow, 0);
        overflow_clr = 1'b0;
        check("t5_level", level, 16);

        // Drain: 01..0F then 55
        m_ready = 1'b1;
        for (int n = 0; n < 40 && level != 0; n++) step();
        m_ready = 1'b0;
        check("t6_drained_level", level, 0);
        check("t6_queue_empty", exp_q.size(), 0);

        // Pointer wrap with 40 push/pop pairs
        for (int i = 0; i < 40; i++) begin
            rx_data = 8'h80 + 8'(i); rx_done = 1'b1;
            exp_q.push_back(8'h80 + 8'(i));
            step();
            rx_done = 1'b0; m_ready = 1'b1;
            step();
            m_ready = 1'b0;
        end
        check("t7_level", level, 0);
        check("t7_queue_empty", exp_q.size(), 0);

        // Seven bytes buffered then lost to an asynchronous reset
        for (int i = 0; i < 7; i++) begin
            rx_data = 8'hE0 + 8'(i); rx_done = 1'b1;
            step();
            rx_done = 1'b0;
            step();
        end
        check("t8_level7", level, 7);
        check("t8_head", m_data, 8'hE0);
        #2 reset_n = 1'b0;
        #1;
        check("t8_rst_valid", m_valid, 0);
        check("t8_rst_data", m_data, 8'h00);
        check("t8_rst_level", level, 0);
        check("t8_rst_afull", almost_full, 0);
        check("t8_rst_ovf", overflow, 0);
        step();
        reset_n = 1'b1;
        step();
        rx_data = 8'hC3; rx_done = 1'b1;
        exp_q.push_back(8'hC3);
        step();
        rx_done = 1'b0;
        check("t8_post_level", level, 1);
        check("t8_post_data", m_data, 8'hC3);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("t8_final_queue", exp_q.size(), 0);
        check("t8_final_level", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte the receiver completes, signalled by its `data_out`/`rx_done` pair. Bytes are held in a first-word-fall-through FIFO and presented to the consumer, the LDPC decoder input stage, over a valid/ready handshake. It absorbs bursts when the consumer stalls and flags lost bytes with a sticky overflow indication.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `AFULL_LVL`, 12: level at or above which `almost_full` asserts; 1..DEPTH.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  byte from the UART receiver (`data_out`).
- `rx_done`  in  1  receiver completion flag; one byte per rising edge.
- `m_data`  out  8  head-of-FIFO byte; 8'h00 when empty.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts the head byte when `m_valid & m_ready`.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `almost_full`  out  1  `level >= AFULL_LVL`.
- `overflow`  out  1  sticky; a byte was dropped.
- `overflow_clr`  in  1  single-cycle clear of `overflow`.

## Operation
- Edge detect: `push = rx_done & ~rx_done_q`, where `rx_done_q` is `rx_done` registered.
  - A level held high for several cycles pushes exactly once.
  - Back-to-back pulses separated by one low cycle push twice.
- `pop = m_valid & m_ready`. A pop while empty is impossible because `m_valid` is low.
- Write: on `push` with the FIFO not full, `mem[wr_ptr] <= rx_data` and `wr_ptr` increments.
- Read: on `pop`, `rd_ptr` increments.
- Pointer width is $clog2(DEPTH). Pointers wrap modulo DEPTH without a gap.
- Level update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop in the same cycle.
- Full with simultaneous push and pop: both are performed, the level stays DEPTH, and no overflow is flagged.
- Full with push and no pop: the byte is discarded, pointers and level are unchanged, and `overflow` is set.
- Empty with push: the byte is written and `level` becomes 1. No bypass path.
- `overflow` is sticky until `overflow_clr`. If a set and a clear occur in the same cycle, set wins.
- `m_data = mem[rd_ptr]` when `level != 0`, else 8'h00.
- Memory contents are not reset.

## Timing
- Reset (`reset_n` low, asynchronous, at any time including mid-burst) drives:
  - `wr_ptr`, `rd_ptr`, `level` = 0.
  - `rx_done_q` = 0.
  - `overflow` = 0.
  - Hence `m_valid` = 0, `m_data` = 8'h00, `almost_full` = 0.
- Buffered bytes are lost on reset. Release is synchronous to the next `clk` edge.
- Push latency: `rx_done` is first sampled high at edge N. The byte is written at edge N and is visible on `m_data`/`m_valid` in the cycle after edge N.
- Pop: the consumer samples `m_data` in the cycle where `m_valid & m_ready`. The next byte or empty status appears after that edge.
- Throughput: one pop per cycle. Push rate is bounded by the edge detector to one per two cycles.
- All outputs are derived from registers only. No combinational path from `m_ready` or `rx_done` to any output.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W = 8`.
  - Byte typedef `uart_byte_t`.
  - Also used by the receiver and transmitter.
- Sub-module `sync_fifo`: generic FWFT storage holding pointers, level and memory, parameterised by width and depth.
- The top level adds the edge detector, overflow flag, `almost_full` compare and empty-data masking.

## Test plan
- Reset, then a single `rx_done` pulse with `rx_data`=8'hA5 and `m_ready`=0 → next cycle `m_valid`=1, `m_data`=8'hA5, `level`=1; `m_ready`=1 for one cycle → `level`=0, `m_data`=8'h00.
- `rx_done` held high for 5 cycles with `rx_data`=8'h3C → exactly one entry, `level`=1.
- 17 pushes of 8'h00..8'h10 with `m_ready`=0 and DEPTH=16 →
  - `level`=16; `almost_full` first asserts at level 12.
  - `overflow`=1; 8'h10 is dropped.
  - Draining yields 8'h00..8'h0F in order.
- Full FIFO, push and pop in the same cycle → level stays 16, `overflow` stays 0, the new byte appears last.
- Overflow set, then `overflow_clr` coinciding with another dropped push → `overflow` remains 1; `overflow_clr` alone next cycle → 0.
- Pointer wrap and reset: 40 push/pop pairs verify data order across the wrap; `reset_n` asserted mid-stream with `level`=7 → all outputs at reset values immediately, and the next push reads back correctly.
